// File: rtl/mold_req_tx_pkg.sv
// Shared constants and types for the MoldUDP64 retransmission-request transmitter.
// Addresses, ports and fixed header fields used by mold_req_tx and crc32_d8.
package mold_req_tx_pkg;

  localparam logic [47:0] DEVICE_MAC        = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETH_IP_V4_TYPE    = 16'h0800;
  localparam logic [31:0] DEVICE_IP         = 32'hC0A8_0164;

  localparam logic [47:0] MOLD_SERVER_MAC   = 48'h0A_1B_2C_3D_4E_5F;
  localparam logic [31:0] MOLD_REQ_IP       = 32'hC0A8_0101;
  localparam logic [15:0] MOLD_REQ_SRC_PORT = 16'h7531;
  localparam logic [15:0] MOLD_REQ_DST_PORT = 16'h7532;
  localparam int unsigned MOLD_REQ_FRAME_LEN = 62;
  localparam int unsigned MOLD_REQ_FCS_LEN   = 4;

  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [15:0] IP_TOTAL_LEN  = 16'h0030;
  localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_LEN       = 16'h001C;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

  typedef struct packed {
    logic [79:0] sessId;
    logic [63:0] seqNum;
    logic [15:0] msgCnt;
  } moldReqType;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CSUM,
    ST_SEND,
    ST_IFG
  } txStateType;

endpackage

// File: rtl/mold_req_tx_crc32_d8.sv
// crc32_d8: byte-serial reflected IEEE 802.3 CRC32 (raw register, no final inversion).
// crcNextOut exposes the value after absorbing dataIn so the caller can use it in the same cycle.
module crc32_d8
  import mold_req_tx_pkg::*;
(
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        enIn,
  input  logic        initIn,
  input  logic [7:0]  dataIn,
  output logic [31:0] crcOut,
  output logic [31:0] crcNextOut
);

  logic [31:0] r_crc;
  logic [31:0] w_crcNext;

  always_comb begin
    w_crcNext = r_crc ^ {24'h0, dataIn};
    for (int unsigned i = 0; i < 8; i++) begin
      w_crcNext = w_crcNext[0] ? ((w_crcNext >> 1) ^ CRC32_POLY) : (w_crcNext >> 1);
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_crc <= '1;
    end else if (initIn) begin
      r_crc <= '1;
    end else if (enIn) begin
      r_crc <= w_crcNext;
    end
  end

  assign crcOut     = r_crc;
  assign crcNextOut = w_crcNext;

endmodule

// File: rtl/mold_req_tx.sv
// mold_req_tx: serialises MoldUDP64 retransmission requests as Ethernet/IPv4/UDP byte frames.
// Define MOLD_REQ_FCS_EN to append the CRC32 FCS in-block (66-byte frames) instead of in the MAC.
module mold_req_tx #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter logic [7:0]  IP_TTL     = 8'd64
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        reqValidIn,
  output logic        reqReadyOut,
  input  logic [79:0] reqSessIdIn,
  input  logic [63:0] reqSeqNumIn,
  input  logic [15:0] reqMsgCntIn,
  output logic [7:0]  txDataOut,
  output logic        txValidOut,
  output logic        txLastOut,
  input  logic        txReadyIn,
  output logic        frameSentOut
);
  import mold_req_tx_pkg::*;

`ifdef MOLD_REQ_FCS_EN
  localparam int unsigned FRAME_LEN = MOLD_REQ_FRAME_LEN + MOLD_REQ_FCS_LEN;
`else
  localparam int unsigned FRAME_LEN = MOLD_REQ_FRAME_LEN;
`endif
  localparam logic [6:0]  LAST_IDX = 7'(FRAME_LEN - 1);
  // The frameSentOut cycle counts as the first inter-frame gap cycle.
  localparam logic [31:0] IFG_LAST = (IFG_CYCLES > 1) ? 32'(IFG_CYCLES - 2) : '0;

  txStateType  r_state;
  moldReqType  r_req;
  logic [15:0] r_ipId;
  logic [15:0] r_chk;
  logic [16:0] r_acc;
  logic [3:0]  r_csumCnt;
  logic [6:0]  r_idx;
  logic [31:0] r_ifgCnt;
  logic [7:0]  r_txData;
  logic        r_txValid;
  logic        r_txLast;

  logic        w_handshake;
  logic [15:0] w_hdrWord;
  logic [16:0] w_sum;
  logic [15:0] w_fold;
  logic [6:0]  w_nextIdx;
  logic [7:0]  w_nextByte;
  logic [MOLD_REQ_FRAME_LEN*8-1:0] w_frame;

  assign w_handshake = r_txValid & txReadyIn;
  assign w_nextIdx   = r_idx + 7'd1;

  always_comb begin
    w_hdrWord = '0;
    case (r_csumCnt)
      4'd0: w_hdrWord = {IP_VER_IHL, 8'h00};
      4'd1: w_hdrWord = IP_TOTAL_LEN;
      4'd2: w_hdrWord = r_ipId;
      4'd3: w_hdrWord = IP_FLAGS_DF;
      4'd4: w_hdrWord = {IP_TTL, IP_PROTO_UDP};
      4'd5: w_hdrWord = 16'h0000;
      4'd6: w_hdrWord = DEVICE_IP[31:16];
      4'd7: w_hdrWord = DEVICE_IP[15:0];
      4'd8: w_hdrWord = MOLD_REQ_IP[31:16];
      4'd9: w_hdrWord = MOLD_REQ_IP[15:0];
      default: w_hdrWord = '0;
    endcase
  end

  // The accumulator never reaches 0x1FFFF, so one fold after the last word is sufficient.
  assign w_sum  = {1'b0, r_acc[15:0]} + {16'h0, r_acc[16]} + {1'b0, w_hdrWord};
  assign w_fold = w_sum[15:0] + {15'h0, w_sum[16]};

  assign w_frame = {MOLD_SERVER_MAC, DEVICE_MAC, ETH_IP_V4_TYPE,
                    IP_VER_IHL, 8'h00, IP_TOTAL_LEN, r_ipId, IP_FLAGS_DF,
                    IP_TTL, IP_PROTO_UDP, r_chk, DEVICE_IP, MOLD_REQ_IP,
                    MOLD_REQ_SRC_PORT, MOLD_REQ_DST_PORT, UDP_LEN, 16'h0000,
                    r_req.sessId, r_req.seqNum, r_req.msgCnt};

`ifdef MOLD_REQ_FCS_EN
  logic [31:0] w_crc;
  logic [31:0] w_crcNext;
  logic [31:0] w_fcs;

  crc32_d8 u_crc (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .enIn       (w_handshake && (r_idx < 7'(MOLD_REQ_FRAME_LEN))),
    .initIn     (r_state == ST_CSUM),
    .dataIn     (r_txData),
    .crcOut     (w_crc),
    .crcNextOut (w_crcNext)
  );

  // FCS byte 0 is loaded on the same edge that absorbs the final payload byte.
  assign w_fcs = (r_idx == 7'(MOLD_REQ_FRAME_LEN - 1)) ? ~w_crcNext : ~w_crc;
`endif

  always_comb begin
    w_nextByte = '0;
    for (int unsigned k = 0; k < MOLD_REQ_FRAME_LEN; k++) begin
      if (w_nextIdx == 7'(k)) w_nextByte = w_frame[(MOLD_REQ_FRAME_LEN-1-k)*8 +: 8];
    end
`ifdef MOLD_REQ_FCS_EN
    for (int unsigned k = 0; k < MOLD_REQ_FCS_LEN; k++) begin
      if (w_nextIdx == 7'(MOLD_REQ_FRAME_LEN + k)) w_nextByte = w_fcs[k*8 +: 8];
    end
`endif
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_ipId    <= '0;
      r_chk     <= '0;
      r_acc     <= '0;
      r_csumCnt <= '0;
      r_idx     <= '0;
      r_ifgCnt  <= '0;
      r_txData  <= '0;
      r_txValid <= 1'b0;
      r_txLast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reqValidIn) begin
            r_req.sessId <= reqSessIdIn;
            r_req.seqNum <= reqSeqNumIn;
            r_req.msgCnt <= reqMsgCntIn;
            if (reqMsgCntIn != 16'h0) begin
              r_acc     <= '0;
              r_csumCnt <= '0;
              r_state   <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (r_csumCnt == 4'd9) begin
            r_chk     <= ~w_fold;
            r_idx     <= '0;
            r_txData  <= w_frame[MOLD_REQ_FRAME_LEN*8-1 -: 8];
            r_txValid <= 1'b1;
            r_txLast  <= 1'b0;
            r_state   <= ST_SEND;
          end else begin
            r_acc     <= w_sum;
            r_csumCnt <= r_csumCnt + 4'd1;
          end
        end
        ST_SEND: begin
          if (w_handshake) begin
            if (r_txLast) begin
              r_txValid <= 1'b0;
              r_txLast  <= 1'b0;
              r_txData  <= '0;
              r_ipId    <= r_ipId + 16'd1;
              r_ifgCnt  <= '0;
              r_state   <= (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;
            end else begin
              r_idx    <= w_nextIdx;
              r_txData <= w_nextByte;
              r_txLast <= (w_nextIdx == LAST_IDX);
            end
          end
        end
        ST_IFG: begin
          if (r_ifgCnt == IFG_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_ifgCnt <= r_ifgCnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reqReadyOut  = (r_state == ST_IDLE);
  assign txDataOut    = r_txData;
  assign txValidOut   = r_txValid;
  assign txLastOut    = r_txLast;
  // Qualified by txReadyIn so the pulse coincides with the last-byte handshake.
  assign frameSentOut = r_txValid & r_txLast & txReadyIn;

endmodule

// File: tb/tb_mold_req_tx.sv
// Scoreboard bench for mold_req_tx: stimulus queues expected frame bytes, a monitor pops and compares.
// Builds with or without MOLD_REQ_FCS_EN.
module tb_mold_req_tx;

  localparam int IFG = 12;
`ifdef MOLD_REQ_FCS_EN
  localparam int FLEN = 66;
`else
  localparam int FLEN = 62;
`endif
  localparam logic [47:0] SRV_MAC  = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] DEV_MAC  = 48'h020000000001;
  localparam logic [31:0] DEV_IP   = 32'hC0A80164;
  localparam logic [31:0] REQ_IP   = 32'hC0A80101;
  localparam logic [15:0] SRC_PORT = 16'h7531;
  localparam logic [15:0] DST_PORT = 16'h7532;
  localparam logic [79:0] SESS_A   = 80'h4E595345303030303120; // "NYSE00001 "
  localparam logic [79:0] SESS_B   = 80'h4E41534441513030310A;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        reqValidIn = 1'b0;
  logic        reqReadyOut;
  logic [79:0] reqSessIdIn = '0;
  logic [63:0] reqSeqNumIn = '0;
  logic [15:0] reqMsgCntIn = '0;
  logic [7:0]  txDataOut;
  logic        txValidOut;
  logic        txLastOut;
  logic        txReadyIn = 1'b1;
  logic        frameSentOut;

  mold_req_tx #(.IFG_CYCLES(IFG), .IP_TTL(8'd64)) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .reqValidIn   (reqValidIn),
    .reqReadyOut  (reqReadyOut),
    .reqSessIdIn  (reqSessIdIn),
    .reqSeqNumIn  (reqSeqNumIn),
    .reqMsgCntIn  (reqMsgCntIn),
    .txDataOut    (txDataOut),
    .txValidOut   (txValidOut),
    .txLastOut    (txLastOut),
    .txReadyIn    (txReadyIn),
    .frameSentOut (frameSentOut)
  );

  always #5 clkIn = ~clkIn;

  int unsigned cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp_q[$];
  bit          expl_q[$];
  int unsigned acc_q[$];
  bit          stall_mode = 0;
  int unsigned last_sent_cyc = 0;
  int unsigned last_acc_cyc = 0;
  int          mon_b = 0;
  logic [7:0]  last_rx[0:65];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ip_csum(input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'h0030 + {16'h0, id} + 32'h4000 + 32'h4011 + 32'h0000
      + {16'h0, DEV_IP[31:16]} + {16'h0, DEV_IP[15:0]}
      + {16'h0, REQ_IP[31:16]} + {16'h0, REQ_IP[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  function automatic logic [15:0] ones_sum(input logic [7:0] r[0:65]);
    logic [31:0] s;
    s = '0;
    for (int i = 14; i < 34; i += 2) s = s + {16'h0, r[i], r[i+1]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic push_frame(input logic [15:0] id, input logic [79:0] s,
                            input logic [63:0] q, input logic [15:0] c);
    logic [495:0] v;
    logic [7:0]   f[0:65];
    logic [31:0]  crc;
    v = {SRV_MAC, DEV_MAC, 16'h0800, 8'h45, 8'h00, 16'h0030, id, 16'h4000,
         8'd64, 8'h11, ip_csum(id), DEV_IP, REQ_IP, SRC_PORT, DST_PORT,
         16'h001C, 16'h0000, s, q, c};
    for (int i = 0; i < 62; i++) f[i] = v[495-8*i -: 8];
    crc = '1;
    for (int i = 0; i < 62; i++) begin
      crc = crc ^ {24'h0, f[i]};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) f[62+i] = crc[8*i +: 8];
    for (int i = 0; i < FLEN; i++) begin
      exp_q.push_back(f[i]);
      expl_q.push_back(i == FLEN - 1);
    end
  endtask

  task automatic send_req(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c,
                          input logic [15:0] id, input bit hold, output int waited);
    bit got;
    got = 0;
    waited = 0;
    if (!reqValidIn) begin
      @(posedge clkIn);
      #1;
    end
    reqSessIdIn = s;
    reqSeqNumIn = q;
    reqMsgCntIn = c;
    reqValidIn  = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clkIn);
      waited++;
      if (reqReadyOut) got = 1;
    end
    check("accept_within_bound", 64'(got), 64'd1);
    if (got) begin
      last_acc_cyc = cyc;
      if (c != 16'h0) begin
        acc_q.push_back(cyc);
        push_frame(id, s, q, c);
      end
    end
    @(posedge clkIn);
    #1;
    if (!hold) reqValidIn = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clkIn);
      if (exp_q.size() == 0 && reqReadyOut && !txValidOut) done = 1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clkIn);
      #1;
      txReadyIn = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every accepted byte against the scoreboard and checks stall stability.
  initial begin
    logic [7:0]  rx[0:65];
    logic [7:0]  held_d;
    bit          held_l;
    bit          held_v;
    bit          first_seen;
    int unsigned first_cyc;
    logic [7:0]  ed;
    bit          el;
    held_v = 0;
    first_seen = 0;
    first_cyc = 0;
    held_d = '0;
    held_l = 0;
    for (int i = 0; i < 66; i++) rx[i] = '0;
    forever begin
      @(negedge clkIn);
      if (rstIn) begin
        mon_b = 0;
        held_v = 0;
        first_seen = 0;
      end else begin
        if (held_v) begin
          check("stall_hold_valid", 64'(txValidOut), 64'd1);
          check("stall_hold_data", 64'(txDataOut), 64'(held_d));
          check("stall_hold_last", 64'(txLastOut), 64'(held_l));
        end
        if (txValidOut && !first_seen) begin
          first_seen = 1;
          first_cyc = cyc;
          if (acc_q.size() != 0) check("first_byte_latency", 64'(cyc), 64'(acc_q.pop_front() + 11));
          else check("unexpected_frame_start", 64'(txValidOut), 64'd0);
        end
        if (txValidOut && txReadyIn) begin
          held_v = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 64'(txValidOut), 64'd0);
          end else begin
            ed = exp_q.pop_front();
            el = expl_q.pop_front();
            check($sformatf("byte%0d_data", mon_b), 64'(txDataOut), 64'(ed));
            check($sformatf("byte%0d_last", mon_b), 64'(txLastOut), 64'(el));
            check("frame_sent_on_last", 64'(frameSentOut), 64'(el));
          end
          if (mon_b < 66) rx[mon_b] = txDataOut;
          mon_b++;
          if (txLastOut) begin
            check("ip_hdr_ones_sum", 64'(ones_sum(rx)), 64'hFFFF);
            check("frame_length", 64'(mon_b), 64'(FLEN));
            if (!stall_mode) check("last_byte_latency", 64'(cyc - first_cyc), 64'(FLEN - 1));
            last_sent_cyc = cyc;
            last_rx = rx;
            mon_b = 0;
            first_seen = 0;
          end
        end else begin
          check("frame_sent_idle", 64'(frameSentOut), 64'd0);
          if (txValidOut) begin
            held_v = 1;
            held_d = txDataOut;
            held_l = txLastOut;
          end else begin
            held_v = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int unsigned acc1;
    int unsigned sent1;
    bit got;
    logic [47:0] zeros;

    @(negedge clkIn);
    check("rst_reqReady", 64'(reqReadyOut), 64'd1);
    check("rst_txValid", 64'(txValidOut), 64'd0);
    check("rst_txLast", 64'(txLastOut), 64'd0);
    check("rst_txData", 64'(txDataOut), 64'd0);
    check("rst_frameSent", 64'(frameSentOut), 64'd0);
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;

    // Single request
    send_req(SESS_A, 64'h1234, 16'd5, 16'h0000, 0, w);
    check("single_accept_wait", 64'(w), 64'd1);
    wait_idle("single_done");
    zeros = {last_rx[52], last_rx[53], last_rx[54], last_rx[55], last_rx[56], last_rx[57]};
    check("single_seq_hi", 64'(zeros), 64'd0);
    check("single_seq_lo", 64'({last_rx[58], last_rx[59]}), 64'h1234);
    check("single_cnt", 64'({last_rx[60], last_rx[61]}), 64'h0005);
    check("single_ipid", 64'({last_rx[18], last_rx[19]}), 64'h0000);
    check("single_csum", 64'({last_rx[24], last_rx[25]}), 64'hB707);

    // Back-to-back with reqValidIn held
    send_req(SESS_A, 64'h2000, 16'd2, 16'h0001, 1, w);
    acc1 = last_acc_cyc;
    send_req(SESS_B, 64'hFEDCBA9876543210, 16'd300, 16'h0002, 0, w);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clkIn);
      if (last_sent_cyc > acc1) got = 1;
    end
    sent1 = last_sent_cyc;
    check("b2b_gap_after_sent", 64'(last_acc_cyc - sent1), 64'(IFG));
    check("b2b_ipid1", 64'({last_rx[18], last_rx[19]}), 64'h0001);
    check("b2b_csum1", 64'({last_rx[24], last_rx[25]}), 64'hB706);
    wait_idle("b2b_done");
    check("b2b_ipid2", 64'({last_rx[18], last_rx[19]}), 64'h0002);

    // Random stalls on txReadyIn
    stall_mode = 1;
    send_req(SESS_A, 64'h1234, 16'd5, 16'h0003, 0, w);
    wait_idle("stall_done");
    stall_mode = 0;
    @(posedge clkIn);
    #1;

    // Zero count: consumed, no frame
    send_req(SESS_A, 64'h99, 16'd0, 16'h0000, 0, w);
    check("zero_accept_wait", 64'(w), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clkIn);
      check("zero_no_valid", 64'(txValidOut), 64'd0);
      check("zero_ready", 64'(reqReadyOut), 64'd1);
    end

    // Mid-frame reset at byte 30
    send_req(SESS_B, 64'h55, 16'd3, 16'h0004, 0, w);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clkIn);
      if (mon_b == 30 && txValidOut) got = 1;
    end
    check("reach_byte30", 64'(got), 64'd1);
    @(posedge clkIn);
    #2;
    rstIn = 1'b1;
    #1;
    check("rst_async_valid", 64'(txValidOut), 64'd0);
    check("rst_async_ready", 64'(reqReadyOut), 64'd1);
    exp_q.delete();
    expl_q.delete();
    acc_q.delete();
    @(negedge clkIn);
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    send_req(SESS_B, 64'hABCDEF, 16'd7, 16'h0000, 0, w);
    wait_idle("after_reset_done");
    check("after_reset_ipid", 64'({last_rx[18], last_rx[19]}), 64'h0000);
    check("after_reset_byte0", 64'(last_rx[0]), 64'h0A);

    // IP ID wrap
    force dut.r_ipId = 16'hFFFF;
    @(posedge clkIn);
    #1;
    release dut.r_ipId;
    send_req(SESS_A, 64'h10, 16'd1, 16'hFFFF, 0, w);
    wait_idle("wrap_ffff_done");
    check("wrap_ipid_ffff", 64'({last_rx[18], last_rx[19]}), 64'hFFFF);
    send_req(SESS_A, 64'h11, 16'd1, 16'h0000, 0, w);
    wait_idle("wrap_0000_done");
    check("wrap_ipid_0000", 64'({last_rx[18], last_rx[19]}), 64'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
